// File: rtl/result_display_scanner.sv
// rtl/result_display_scanner.sv - halt detector and 8-digit hex 7-segment scanner for datapath bring-up
//
// Samples v0/v1 every cycle while the program runs, declares program end once
// PC has been parked at HALT_PC for STABLE_CYCLES consecutive cycles, freezes
// the captured values and scans the selected one onto an 8-digit common-anode
// display. Never back-pressures the datapath.
//
// Ports:
//   Clk      system clock (datapath clock)
//   Rst      asynchronous active-low reset
//   PCwire   current PC from the datapath
//   v0_in    register $v0 value
//   v1_in    register $v1 value
//   sel_btn  asynchronous switch: 0 shows v0, 1 shows v1
//   an       digit anodes, active-low one-hot, an[0] = least significant digit
//   seg      segments {g,f,e,d,c,b,a}, active-low
//   dp       decimal point, active-low (lit on digit 0 once halted)
//   halted   high once program end has been detected
//
// Optional feature: define BLANK_LEADING_ZEROS_EN to blank leading zero digits
// (digit 0 is never blanked).

module result_display_scanner #(
    parameter int unsigned REFRESH_DIV   = 100000,
    parameter logic [31:0] HALT_PC       = 32'h0000_0100,
    parameter int unsigned STABLE_CYCLES = 8
) (
    input  logic        Clk,
    input  logic        Rst,
    input  logic [31:0] PCwire,
    input  logic [31:0] v0_in,
    input  logic [31:0] v1_in,
    input  logic        sel_btn,
    output logic [7:0]  an,
    output logic [6:0]  seg,
    output logic        dp,
    output logic        halted
);

    localparam int unsigned      DIV_W       = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST    = DIV_W'(REFRESH_DIV - 1);
    localparam logic [7:0]       STABLE_MAX  = 8'(STABLE_CYCLES);
    localparam logic [7:0]       STABLE_LAST = 8'(STABLE_CYCLES - 1);

    typedef enum logic {
        S_RUN    = 1'b0,
        S_HALTED = 1'b1
    } state_t;

    state_t           state_q;
    logic             halted_q;
    logic [7:0]       stable_cnt_q;
    logic [31:0]      cap_v0_q;
    logic [31:0]      cap_v1_q;
    logic             sel_meta_q;
    logic             sel_sync_q;
    logic [DIV_W-1:0] div_cnt_q;
    logic [DIV_W-1:0] div_cnt_d;
    logic [2:0]       digit_idx_q;
    logic [2:0]       digit_idx_d;
    logic [7:0]       an_q;
    logic [7:0]       an_d;
    logic [6:0]       seg_q;
    logic [6:0]       seg_d;
    logic             dp_q;
    logic             dp_d;

    logic             div_wrap;
    logic             pc_at_halt;
    logic [31:0]      sel_val;
    logic [3:0]       nibble;
    logic             blank;

    function automatic logic [6:0] hex7(input logic [3:0] n);
        logic [6:0] s;
        case (n)
            4'h0: s = 7'b1000000;
            4'h1: s = 7'b1111001;
            4'h2: s = 7'b0100100;
            4'h3: s = 7'b0110000;
            4'h4: s = 7'b0011001;
            4'h5: s = 7'b0010010;
            4'h6: s = 7'b0000010;
            4'h7: s = 7'b1111000;
            4'h8: s = 7'b0000000;
            4'h9: s = 7'b0010000;
            4'hA: s = 7'b0001000;
            4'hB: s = 7'b0000011;
            4'hC: s = 7'b1000110;
            4'hD: s = 7'b0100001;
            4'hE: s = 7'b0000110;
            default: s = 7'b0001110;
        endcase
        return s;
    endfunction

    // Display path. Everything here looks at the index the digit registers will
    // hold after the edge, but at the capture/sel/halted values from before it,
    // so a freeze on the same edge as an update still shows the pre-freeze data.
    always_comb begin
        div_wrap    = (div_cnt_q == DIV_LAST);
        div_cnt_d   = div_wrap ? '0 : div_cnt_q + 1'b1;
        digit_idx_d = div_wrap ? digit_idx_q + 3'd1 : digit_idx_q;
        pc_at_halt  = (PCwire == HALT_PC);
        sel_val     = sel_sync_q ? cap_v1_q : cap_v0_q;
        nibble      = sel_val[{digit_idx_d, 2'b00} +: 4];
`ifdef BLANK_LEADING_ZEROS_EN
        // Blank when this digit and every more-significant digit are zero.
        blank       = (digit_idx_d != 3'd0) && ((sel_val >> {digit_idx_d, 2'b00}) == 32'd0);
`else
        blank       = 1'b0;
`endif
        seg_d       = blank ? 7'h7F : hex7(nibble);
        an_d        = ~(8'b1 << digit_idx_d);
        dp_d        = ~(halted_q && (digit_idx_d == 3'd0));
    end

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            state_q      <= S_RUN;
            halted_q     <= 1'b0;
            stable_cnt_q <= 8'd0;
            cap_v0_q     <= 32'd0;
            cap_v1_q     <= 32'd0;
            sel_meta_q   <= 1'b0;
            sel_sync_q   <= 1'b0;
            div_cnt_q    <= '0;
            digit_idx_q  <= 3'd0;
            an_q         <= 8'hFF;
            seg_q        <= 7'h7F;
            dp_q         <= 1'b1;
        end else begin
            // Two-flop synchronizer for the board switch; no debounce.
            sel_meta_q <= sel_btn;
            sel_sync_q <= sel_meta_q;

            case (state_q)
                S_RUN: begin
                    cap_v0_q <= v0_in;
                    cap_v1_q <= v1_in;
                    if (pc_at_halt) begin
                        if (stable_cnt_q == STABLE_LAST) begin
                            state_q  <= S_HALTED;
                            halted_q <= 1'b1;
                        end
                        if (stable_cnt_q != STABLE_MAX) begin
                            stable_cnt_q <= stable_cnt_q + 8'd1;
                        end
                    end else begin
                        stable_cnt_q <= 8'd0;
                    end
                end
                S_HALTED: begin
                    halted_q <= 1'b1;
                end
                default: begin
                    state_q <= S_RUN;
                end
            endcase

            div_cnt_q   <= div_cnt_d;
            digit_idx_q <= digit_idx_d;
            if (div_wrap) begin
                an_q  <= an_d;
                seg_q <= seg_d;
                dp_q  <= dp_d;
            end
        end
    end

    assign an     = an_q;
    assign seg    = seg_q;
    assign dp     = dp_q;
    assign halted = halted_q;

endmodule

// File: tb/tb_result_display_scanner.sv
// tb/tb_result_display_scanner.sv - directed self-checking bench for result_display_scanner

module tb_result_display_scanner;

    localparam int unsigned R  = 4;
    localparam int unsigned SC = 3;

    localparam logic [6:0] S0 = 7'b1000000;
    localparam logic [6:0] S1 = 7'b1111001;
    localparam logic [6:0] S2 = 7'b0100100;
    localparam logic [6:0] S3 = 7'b0110000;
    localparam logic [6:0] S4 = 7'b0011001;
    localparam logic [6:0] S5 = 7'b0010010;
    localparam logic [6:0] S6 = 7'b0000010;
    localparam logic [6:0] S7 = 7'b1111000;
    localparam logic [6:0] S8 = 7'b0000000;
    localparam logic [6:0] S9 = 7'b0010000;
    localparam logic [6:0] SA = 7'b0001000;
    localparam logic [6:0] SB = 7'b0000011;
    localparam logic [6:0] SCc = 7'b1000110;
    localparam logic [6:0] SD = 7'b0100001;
    localparam logic [6:0] SE = 7'b0000110;
    localparam logic [6:0] SF = 7'b0001110;
    localparam logic [6:0] BL = 7'h7F;
`ifdef BLANK_LEADING_ZEROS_EN
    localparam logic [6:0] LZ = BL;
`else
    localparam logic [6:0] LZ = S0;
`endif

    logic        Clk;
    logic        Rst;
    logic [31:0] PCwire;
    logic [31:0] v0_in;
    logic [31:0] v1_in;
    logic        sel_btn;
    logic [7:0]  an;
    logic [6:0]  seg;
    logic        dp;
    logic        halted;

    int checks;
    int errors;

    result_display_scanner #(
        .REFRESH_DIV   (R),
        .HALT_PC       (32'h0000_0100),
        .STABLE_CYCLES (SC)
    ) dut (
        .Clk     (Clk),
        .Rst     (Rst),
        .PCwire  (PCwire),
        .v0_in   (v0_in),
        .v1_in   (v1_in),
        .sel_btn (sel_btn),
        .an      (an),
        .seg     (seg),
        .dp      (dp),
        .halted  (halted)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    typedef struct packed {
        logic [31:0]     v0;
        logic [31:0]     v1;
        logic            sel;
        logic [7:0][6:0] exp;
    } vec_t;

    vec_t vecs [6];

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", name, got, exp);
        end
    endtask

    // Observe one full frame and compare every digit's segments and dp.
    task automatic scan_frame(input string name, input logic [7:0][6:0] exp, input logic [7:0] exp_dp);
        logic [7:0][6:0] got;
        logic [7:0]      gdp;
        logic [7:0]      seen;
        logic [7:0]      m;
        int              bad;
        logic            found;
        got  = '1;
        gdp  = '1;
        seen = '0;
        bad  = 0;
        for (int c = 0; c < 8 * R; c++) begin
            @(negedge Clk);
            found = 1'b0;
            for (int i = 0; i < 8; i++) begin
                m = ~(8'b1 << i);
                if (an == m) begin
                    got[i]  = seg;
                    gdp[i]  = dp;
                    seen[i] = 1'b1;
                    found   = 1'b1;
                end
            end
            if (!found) bad++;
        end
        chk($sformatf("%s an_not_onehot", name), 32'(bad), 32'd0);
        chk($sformatf("%s digits_seen", name), {24'd0, seen}, 32'hFF);
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("%s seg_d%0d", name, i), {25'd0, got[i]}, {25'd0, exp[i]});
        end
        chk($sformatf("%s dp", name), {24'd0, gdp}, {24'd0, exp_dp});
    endtask

    task automatic settle();
        repeat (8 * R + 4) @(posedge Clk);
    endtask

    logic [31:0] pcs [6];
    logic        hexp [6];
    logic [7:0]  exp_an;

    initial begin
        checks = 0;
        errors = 0;

        vecs[0] = '{v0: 32'h1234ABCD, v1: 32'h0, sel: 1'b0,
                    exp: {S1, S2, S3, S4, SA, SB, SCc, SD}};
        vecs[1] = '{v0: 32'h0, v1: 32'h89EF0567, sel: 1'b1,
                    exp: {S8, S9, SE, SF, S0, S5, S6, S7}};
        vecs[2] = '{v0: 32'h0, v1: 32'h89EF0567, sel: 1'b0,
                    exp: {LZ, LZ, LZ, LZ, LZ, LZ, LZ, S0}};
        vecs[3] = '{v0: 32'hFFFFFFFF, v1: 32'h000000A0, sel: 1'b1,
                    exp: {LZ, LZ, LZ, LZ, LZ, LZ, SA, S0}};
        vecs[4] = '{v0: 32'hFFFFFFFF, v1: 32'h0, sel: 1'b1,
                    exp: {LZ, LZ, LZ, LZ, LZ, LZ, LZ, S0}};
        vecs[5] = '{v0: 32'h00F00001, v1: 32'h0, sel: 1'b0,
                    exp: {LZ, LZ, SF, S0, S0, S0, S0, S1}};

        // Reset and scan start-up timing.
        Rst     = 1'b0;
        PCwire  = 32'h0;
        v0_in   = 32'h1234ABCD;
        v1_in   = 32'h0;
        sel_btn = 1'b0;
        repeat (3) @(posedge Clk);
        #1;
        chk("reset an", {24'd0, an}, 32'hFF);
        chk("reset seg", {25'd0, seg}, 32'h7F);
        chk("reset dp", {31'd0, dp}, 32'd1);
        chk("reset halted", {31'd0, halted}, 32'd0);
        @(negedge Clk);
        Rst = 1'b1;
        for (int k = 1; k <= 32; k++) begin
            @(posedge Clk);
            #1;
            exp_an = (k < 4) ? 8'hFF : ~(8'b1 << ((k / 4) % 8));
            chk($sformatf("startup an k%0d", k), {24'd0, an}, {24'd0, exp_an});
            if (k == 1) begin
                chk("startup seg blank", {25'd0, seg}, 32'h7F);
                chk("startup dp", {31'd0, dp}, 32'd1);
            end
            if (k == 4) chk("first update seg", {25'd0, seg}, {25'd0, SCc});
        end

        // Table-driven display vectors while running.
        for (int v = 0; v < 6; v++) begin
            @(negedge Clk);
            v0_in   = vecs[v].v0;
            v1_in   = vecs[v].v1;
            sel_btn = vecs[v].sel;
            settle();
            scan_frame($sformatf("vec%0d", v), vecs[v].exp, 8'hFF);
        end
        chk("no halt while running", {31'd0, halted}, 32'd0);

        // Halt detection: broken run of two, then three consecutive.
        pcs[0] = 32'h100; pcs[1] = 32'h100; pcs[2] = 32'h104;
        pcs[3] = 32'h100; pcs[4] = 32'h100; pcs[5] = 32'h100;
        hexp[0] = 0; hexp[1] = 0; hexp[2] = 0; hexp[3] = 0; hexp[4] = 0; hexp[5] = 1;
        @(negedge Clk);
        v0_in   = 32'h5;
        v1_in   = 32'hF;
        sel_btn = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge Clk);
            PCwire = pcs[i];
            @(posedge Clk);
            #1;
            chk($sformatf("halt seq %0d", i), {31'd0, halted}, {31'd0, hexp[i]});
        end

        // Frozen capture: later input changes must not show.
        @(negedge Clk);
        v0_in  = 32'hFFFFFFFF;
        v1_in  = 32'h12345678;
        PCwire = 32'h200;
        settle();
        scan_frame("halted v0", {LZ, LZ, LZ, LZ, LZ, LZ, LZ, S5}, 8'hFE);
        chk("halted sticky", {31'd0, halted}, 32'd1);

        @(negedge Clk);
        sel_btn = 1'b1;
        settle();
        scan_frame("halted v1", {LZ, LZ, LZ, LZ, LZ, LZ, LZ, SF}, 8'hFE);

        // Asynchronous reset mid-digit, then halt detection restarts.
        @(posedge Clk);
        #2;
        Rst = 1'b0;
        #1;
        chk("async rst an", {24'd0, an}, 32'hFF);
        chk("async rst seg", {25'd0, seg}, 32'h7F);
        chk("async rst dp", {31'd0, dp}, 32'd1);
        chk("async rst halted", {31'd0, halted}, 32'd0);
        @(negedge Clk);
        PCwire = 32'h100;
        Rst    = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge Clk);
            #1;
            chk($sformatf("rehalt %0d", i), {31'd0, halted}, (i == 2) ? 32'd1 : 32'd0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/result_display_scanner.md
Name: result_display_scanner

Overview:
Downstream consumer of the pipelined datapath's observable outputs (PCwire, v0, v1) for board bring-up. It samples v0/v1 every cycle while the program runs and detects program end as PC parked at a halt address. It then freezes the captured results and time-multiplexes the selected 32-bit value as 8 hex digits onto an 8-digit common-anode 7-segment display. Purely observational; it never back-pressures the datapath.

Parameters:
REFRESH_DIV, 100000, clocks per digit slot; legal range 2..2^20.
HALT_PC, 32'h0000_0100, PC value that marks the end-of-program self-loop.
STABLE_CYCLES, 8, consecutive cycles PC must equal HALT_PC before halt is declared; legal range 1..255.

Ports:
Clk  input  1  system clock, same clock as the datapath.
Rst  input  1  reset; one clock; reset is asynchronous and active-low.
PCwire  input  32  current PC from the datapath.
v0_in  input  32  register $v0 value.
v1_in  input  32  register $v1 value.
sel_btn  input  1  asynchronous board switch: 0 shows v0, 1 shows v1.
an  output  8  digit anodes, active-low, one-hot; an[0] is the least significant digit.
seg  output  7  segments {g,f,e,d,c,b,a}, active-low.
dp  output  1  decimal point, active-low.
halted  output  1  high once program end is detected.

Behaviour:
- Reset (Rst=0, async): an=8'hFF, seg=7'h7F, dp=1, halted=0. Divider, digit index, stable counter, capture registers and synchronizer all clear to 0. The FSM enters RUN.
- sel_btn passes through a 2-flop synchronizer. The display uses sel_sync, which lags the pin by 2 cycles. There is no debounce.
- FSM states: RUN and HALTED.
  - RUN: cap_v0<=v0_in and cap_v1<=v1_in every cycle.
    - stable_cnt increments (saturating at STABLE_CYCLES) while PCwire==HALT_PC. It clears to 0 on any cycle with PCwire!=HALT_PC.
    - When stable_cnt reaches STABLE_CYCLES-1 and PCwire==HALT_PC on the same cycle, the FSM goes to HALTED on that edge. halted=1 and the capture freezes at that edge's sample.
  - HALTED: capture registers hold and PCwire is ignored. Only Rst leaves this state.
- Scan:
  - div_cnt counts 0..REFRESH_DIV-1 and wraps.
  - On each wrap, digit_idx increments 0..7 and wraps 7->0.
  - an, seg and dp are registered and update on the same edge that digit_idx changes, using the new index.
  - Digit value = nibble [4*idx+3 : 4*idx] of (sel_sync ? cap_v1 : cap_v0). The nibble is sampled at the update edge.
  - Each digit is lit for exactly REFRESH_DIV cycles. A full frame is 8*REFRESH_DIV cycles.
  - The first digit update occurs REFRESH_DIV cycles after reset release, on digit 1. Outputs stay blanked until then.
- Hex encoding, active-low:
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000
  - 8=0000000, 9=0010000, A=0001000, b=0000011, C=1000110, d=0100001, E=0000110, F=0001110
- dp=0 only when halted=1 and the lit digit is digit 0; otherwise dp=1.
- Simultaneous events:
  - A halt transition and a scan update on the same edge: the scan uses the pre-freeze capture, because capture and display registers both sample old values.
  - sel_sync changing mid-frame takes effect at the next digit update; the frame is not restarted.
- Reset mid-frame or in HALTED: everything returns to reset values immediately, and halt detection restarts.

Optional Feature:
Macro BLANK_LEADING_ZEROS_EN.
- When defined: a digit is blanked (seg=7'h7F, its an still driven low) if it and all more-significant digits of the selected value are 0. Digit 0 is never blanked, so a value of 0 shows a single "0".
- When undefined: all 8 digits are always shown, including leading zeros.
- dp behaviour is unchanged in both cases.

Test Plan:
1. REFRESH_DIV=4. Hold Rst=0 for 3 cycles, then release -> an=FF, seg=7F, dp=1, halted=0 until cycle 4 after release; then an=8'b11111101. Each subsequent digit changes every 4 cycles, and an[0] is low at cycle 32.
2. v0_in=32'h1234ABCD, sel_btn=0, PCwire≠HALT_PC -> over one frame, digits 0..7 show D,C,b,A,4,3,2,1 (digit 0 seg=0100001, digit 7 seg=1111001).
3. STABLE_CYCLES=3, HALT_PC=0x100. Drive PCwire=0x100 for 2 cycles, then 0x104, then 0x100 for 3 cycles -> halted rises on the 3rd consecutive cycle only. Changing v0_in afterwards leaves the displayed digits unchanged, and dp=0 only on digit 0.
4. In HALTED with cap_v0=0x5, cap_v1=0xF, toggle sel_btn to 1 -> after 2 sync cycles, the next update of digit 0 shows F (0001110) instead of 5.
5. Assert Rst low in HALTED mid-digit -> an=FF, seg=7F, dp=1, halted=0 asynchronously, without waiting for a clock edge.
6. With BLANK_LEADING_ZEROS_EN and v1=32'h0000_00A0 selected -> digits 7..2 show seg=7F, digit 1 shows A, digit 0 shows 0. With v1=0, only digit 0 is lit, showing 0.
